// File: rtl/mult_div.sv
// Multicycle signed multiply/divide unit with architectural HI/LO (mult, div, mthi, mtlo).
// Optional macro DIV_ZERO_DETECT_EN: early exit on divide-by-zero plus sticky div_zero flag.
module mult_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic        div_zero
`endif
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FIX} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  count_reg;
    logic        op_reg;
    logic        sign_a_reg;
    logic        sign_b_reg;
    logic [31:0] operand_reg;
    logic [63:0] work_reg;
    logic        skip_write;

    logic [31:0] abs_a, abs_b;
    logic [32:0] mult_sum;
    logic [63:0] mult_step;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_diff;
    logic [63:0] div_step;
    logic [63:0] prod_signed;
    logic [31:0] quot_signed, rem_signed;
    logic [63:0] fix_result;
    logic        zero_div;

    assign abs_a = a[31] ? (~a + 32'd1) : a;
    assign abs_b = b[31] ? (~b + 32'd1) : b;

`ifdef DIV_ZERO_DETECT_EN
    logic zero_reg;
    assign zero_div   = op && (b == 32'd0);
    assign skip_write = zero_reg;
`else
    assign zero_div   = 1'b0;
    assign skip_write = 1'b0;
`endif

    // Multiply: upper half accumulates, multiplier bits shift out of the lower half.
    assign mult_sum  = {1'b0, work_reg[63:32]} + (work_reg[0] ? {1'b0, operand_reg} : 33'd0);
    assign mult_step = {mult_sum, work_reg[31:1]};

    // Restoring divide: {remainder, dividend/quotient}; the shifted remainder needs 33 bits.
    assign rem_shift = work_reg[63:31];
    assign rem_ge    = rem_shift >= {1'b0, operand_reg};
    assign rem_diff  = rem_shift[31:0] - operand_reg;
    assign div_step  = rem_ge ? {rem_diff, work_reg[30:0], 1'b1} : {work_reg[62:0], 1'b0};

    assign prod_signed = (sign_a_reg ^ sign_b_reg) ? (~work_reg + 64'd1) : work_reg;
    assign quot_signed = (sign_a_reg ^ sign_b_reg) ? (~work_reg[31:0] + 32'd1) : work_reg[31:0];
    assign rem_signed  = sign_a_reg ? (~work_reg[63:32] + 32'd1) : work_reg[63:32];
    assign fix_result  = op_reg ? {rem_signed, quot_signed} : prod_signed;

    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (zero_div) begin
                        state_next = FIX;
                    end else begin
                        state_next = op ? DIV : MULT;
                    end
                end
            end
            MULT, DIV: begin
                if (count_reg == 5'd31) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done        <= 1'b0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            count_reg   <= 5'd0;
            op_reg      <= 1'b0;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            operand_reg <= 32'd0;
            work_reg    <= 64'd0;
`ifdef DIV_ZERO_DETECT_EN
            zero_reg    <= 1'b0;
            div_zero    <= 1'b0;
`endif
        end else begin
            done <= (state_reg == FIX);
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg      <= op;
                        sign_a_reg  <= a[31];
                        sign_b_reg  <= b[31];
                        count_reg   <= 5'd0;
                        operand_reg <= op ? abs_b : abs_a;
                        work_reg    <= {32'd0, op ? abs_a : abs_b};
`ifdef DIV_ZERO_DETECT_EN
                        zero_reg    <= zero_div;
                        div_zero    <= 1'b0;
`endif
                    end else begin
                        if (hi_we) begin
                            hi <= a;
                        end
                        if (lo_we) begin
                            lo <= a;
                        end
                    end
                end
                MULT: begin
                    work_reg  <= mult_step;
                    count_reg <= count_reg + 5'd1;
                end
                DIV: begin
                    work_reg  <= div_step;
                    count_reg <= count_reg + 5'd1;
                end
                FIX: begin
                    if (!skip_write) begin
                        hi <= fix_result[63:32];
                        lo <= fix_result[31:0];
                    end
`ifdef DIV_ZERO_DETECT_EN
                    if (zero_reg) begin
                        div_zero <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
